sd_cmd_sequencer: RTL and testbench

Wishbone master that sequences one SD command through the sd_controller_wb register file on behalf of a simple request port. It clears cmd_isr, writes command, then writes argument (which fires cmd_start), and polls cmd_isr until complete, error or poll timeout. It then reads resp0..resp3 and clears cmd_isr again. It sits between a host-side engine (init FSM / DMA driver) and the controller's Wishbone slave port.

---
 rtl/sd_cmd_sequencer_pkg.sv | 30 +++
 rtl/sd_wbm_xfer.sv | 82 ++++++++
 rtl/sd_cmd_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_sd_cmd_sequencer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_cmd_sequencer_pkg.sv
// rtl/sd_cmd_sequencer_pkg.sv - shared sizes, register map and FSM states for the SD command sequencer
package sd_cmd_sequencer_pkg;

  localparam int CMD_REG_SIZE = 14;
  localparam int INT_CMD_SIZE = 5;

  localparam logic [7:0] ADR_ARGUMENT = 8'h00;
  localparam logic [7:0] ADR_COMMAND  = 8'h04;
  localparam logic [7:0] ADR_RESP0    = 8'h08;
  localparam logic [7:0] ADR_CMD_ISR  = 8'h34;

  localparam int INT_CMD_CC   = 0;
  localparam int INT_CMD_EI   = 1;
  localparam int INT_CMD_CTE  = 2;
  localparam int INT_CMD_CCRC = 3;
  localparam int INT_CMD_CIE  = 4;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CLR0,
    ST_WCMD,
    ST_WARG,
    ST_GAP,
    ST_POLL,
    ST_RESP,
    ST_CLR1,
    ST_DONE
  } seq_state_e;

endpackage

// File: rtl/sd_wbm_xfer.sv
// rtl/sd_wbm_xfer.sv - single-transfer Wishbone master; one go launches one registered cycle
module sd_wbm_xfer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go_i,
  input  logic        we_i,
  input  logic [7:0]  adr_i,
  input  logic [31:0] wdat_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic [7:0]  wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  input  logic        wbm_ack_i
);

  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [7:0]  adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic        done_q, done_d;
  logic [31:0] rdata_q, rdata_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      done_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
    end
  end

  // A go is only taken with the bus idle, so the cycle after an ack is always cyc=0.
  always_comb begin
    cyc_d   = cyc_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    done_d  = 1'b0;
    rdata_d = rdata_q;
    if (!cyc_q) begin
      if (go_i) begin
        cyc_d = 1'b1;
        we_d  = we_i;
        adr_d = adr_i;
        dat_d = wdat_i;
      end
    end else if (wbm_ack_i) begin
      cyc_d  = 1'b0;
      we_d   = 1'b0;
      adr_d  = '0;
      dat_d  = '0;
      done_d = 1'b1;
      if (!we_q) rdata_d = wbm_dat_i;
    end
  end

  assign busy_o    = cyc_q;
  assign done_o    = done_q;
  assign rdata_o   = rdata_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign wbm_sel_o = {4{cyc_q}};
  assign wbm_we_o  = we_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;

endmodule

// File: rtl/sd_cmd_sequencer.sv
// rtl/sd_cmd_sequencer.sv - drives one SD command through the controller register file and polls for completion
module sd_cmd_sequencer
  import sd_cmd_sequencer_pkg::*;
#(
  parameter int POLL_GAP  = 4,
  parameter int MAX_POLLS = 1024
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_n_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [CMD_REG_SIZE-1:0] req_cmd_i,
  input  logic [31:0]             req_arg_i,
  input  logic                    req_long_i,
  output logic [7:0]              wbm_adr_o,
  output logic [31:0]             wbm_dat_o,
  input  logic [31:0]             wbm_dat_i,
  output logic [3:0]              wbm_sel_o,
  output logic                    wbm_we_o,
  output logic                    wbm_cyc_o,
  output logic                    wbm_stb_o,
  input  logic                    wbm_ack_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [INT_CMD_SIZE-1:0] isr_o,
  output logic                    seq_timeout_o,
  output logic [31:0]             resp0_o,
  output logic [31:0]             resp1_o,
  output logic [31:0]             resp2_o,
  output logic [31:0]             resp3_o
);

  localparam int PCW = $clog2(MAX_POLLS + 1);
  localparam int GW  = $clog2(POLL_GAP + 1);
  localparam logic [PCW-1:0] POLL_LIMIT = PCW'(MAX_POLLS);
  localparam logic [GW-1:0]  GAP_LAST   = GW'(POLL_GAP - 1);

  seq_state_e              state_q, state_d;
  logic [CMD_REG_SIZE-1:0] cmd_q, cmd_d;
  logic [31:0]             arg_q, arg_d;
  logic                    long_q, long_d;
  logic [PCW-1:0]          poll_cnt_q, poll_cnt_d;
  logic [GW-1:0]           gap_cnt_q, gap_cnt_d;
  logic [1:0]              idx_q, idx_d;
  logic [INT_CMD_SIZE-1:0] isr_q, isr_d;
  logic                    timeout_q, timeout_d;
  logic [31:0]             resp_q [4];
  logic [31:0]             resp_d [4];

  logic        go, go_we, x_busy, x_done;
  logic [7:0]  go_adr;
  logic [31:0] go_dat, x_rdata;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q    <= ST_IDLE;
      cmd_q      <= '0;
      arg_q      <= '0;
      long_q     <= 1'b0;
      poll_cnt_q <= '0;
      gap_cnt_q  <= '0;
      idx_q      <= '0;
      isr_q      <= '0;
      timeout_q  <= 1'b0;
      for (int i = 0; i < 4; i++) resp_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      arg_q      <= arg_d;
      long_q     <= long_d;
      poll_cnt_q <= poll_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      idx_q      <= idx_d;
      isr_q      <= isr_d;
      timeout_q  <= timeout_d;
      for (int i = 0; i < 4; i++) resp_q[i] <= resp_d[i];
    end
  end

  // Each transition into a bus state launches its transfer in the same cycle the previous one completes.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    arg_d      = arg_q;
    long_d     = long_q;
    poll_cnt_d = poll_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    idx_d      = idx_q;
    isr_d      = isr_q;
    timeout_d  = timeout_q;
    resp_d     = resp_q;
    go         = 1'b0;
    go_we      = 1'b0;
    go_adr     = ADR_CMD_ISR;
    go_dat     = '0;
    case (state_q)
      ST_IDLE: if (req_valid_i) begin
        cmd_d      = req_cmd_i;
        arg_d      = req_arg_i;
        long_d     = req_long_i;
        poll_cnt_d = '0;
        timeout_d  = 1'b0;
        state_d    = ST_CLR0;
        go         = 1'b1;
        go_we      = 1'b1;
      end
      ST_CLR0: if (x_done) begin
        state_d = ST_WCMD;
        go      = 1'b1;
        go_we   = 1'b1;
        go_adr  = ADR_COMMAND;
        go_dat  = 32'(cmd_q);
      end
      ST_WCMD: if (x_done) begin
        state_d = ST_WARG;
        go      = 1'b1;
        go_we   = 1'b1;
        go_adr  = ADR_ARGUMENT;
        go_dat  = arg_q;
      end
      ST_WARG: if (x_done) begin
        state_d   = ST_GAP;
        gap_cnt_d = '0;
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = ST_POLL;
          go      = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      ST_POLL: if (x_done) begin
        isr_d = x_rdata[INT_CMD_SIZE-1:0];
        if (x_rdata[INT_CMD_CC] || x_rdata[INT_CMD_EI]) begin
          state_d = ST_RESP;
          idx_d   = '0;
          go      = 1'b1;
          go_adr  = ADR_RESP0;
        end else begin
          poll_cnt_d = poll_cnt_q + 1'b1;
          if (poll_cnt_d == POLL_LIMIT) begin
            state_d   = ST_CLR1;
            timeout_d = 1'b1;
            go        = 1'b1;
            go_we     = 1'b1;
          end else begin
            state_d   = ST_GAP;
            gap_cnt_d = '0;
          end
        end
      end
      ST_RESP: if (x_done) begin
        resp_d[idx_q] = x_rdata;
        go            = 1'b1;
        if (long_q && idx_q != 2'd3) begin
          idx_d  = idx_q + 1'b1;
          go_adr = ADR_RESP0 + {4'd0, idx_d, 2'b00};
        end else begin
          state_d = ST_CLR1;
          go_we   = 1'b1;
        end
      end
      ST_CLR1: if (x_done) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  sd_wbm_xfer u_xfer (
    .clk       (wb_clk_i),
    .rst_n     (wb_rst_n_i),
    .go_i      (go & ~x_busy),
    .we_i      (go_we),
    .adr_i     (go_adr),
    .wdat_i    (go_dat),
    .busy_o    (x_busy),
    .done_o    (x_done),
    .rdata_o   (x_rdata),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_dat_i (wbm_dat_i),
    .wbm_sel_o (wbm_sel_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_ack_i (wbm_ack_i)
  );

  assign req_ready_o   = (state_q == ST_IDLE) && wb_rst_n_i;
  assign busy_o        = (state_q != ST_IDLE);
  assign done_o        = (state_q == ST_DONE);
  assign isr_o         = isr_q;
  assign seq_timeout_o = timeout_q;
  assign resp0_o       = resp_q[0];
  assign resp1_o       = resp_q[1];
  assign resp2_o       = resp_q[2];
  assign resp3_o       = resp_q[3];

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// tb/tb_sd_cmd_sequencer.sv - directed bench with a register-file slave model for sd_cmd_sequencer
module tb_sd_cmd_sequencer;
  import sd_cmd_sequencer_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid, req_ready, req_long;
  logic [13:0] req_cmd;
  logic [31:0] req_arg;
  logic [7:0]  wbm_adr;
  logic [31:0] wbm_dat_o, wbm_dat_i;
  logic [3:0]  wbm_sel;
  logic        wbm_we, wbm_cyc, wbm_stb;
  logic        wbm_ack = 1'b0;
  logic        busy, done, seq_timeout;
  logic [4:0]  isr;
  logic [31:0] resp0, resp1, resp2, resp3;

  sd_cmd_sequencer #(.POLL_GAP(2), .MAX_POLLS(8)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_cmd_i(req_cmd),
    .req_arg_i(req_arg), .req_long_i(req_long),
    .wbm_adr_o(wbm_adr), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
    .wbm_sel_o(wbm_sel), .wbm_we_o(wbm_we), .wbm_cyc_o(wbm_cyc),
    .wbm_stb_o(wbm_stb), .wbm_ack_i(wbm_ack),
    .busy_o(busy), .done_o(done), .isr_o(isr), .seq_timeout_o(seq_timeout),
    .resp0_o(resp0), .resp1_o(resp1), .resp2_o(resp2), .resp3_o(resp3)
  );

  int tests = 0;
  int fails = 0;

  int          poll_reads = 0;
  int          raise_after = 0;
  logic [4:0]  raise_val = 5'h0;
  logic [31:0] rr [4];
  logic [40:0] log_q [$];
  int          arg_writes = 0;
  int          done_cnt = 0;
  int          sel_err = 0;

  always_comb begin
    wbm_dat_i = 32'h0;
    case (wbm_adr)
      ADR_CMD_ISR: wbm_dat_i = (poll_reads >= raise_after) ? {27'h0, raise_val} : 32'h0;
      8'h08: wbm_dat_i = rr[0];
      8'h0c: wbm_dat_i = rr[1];
      8'h10: wbm_dat_i = rr[2];
      8'h14: wbm_dat_i = rr[3];
      default: wbm_dat_i = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    if (wbm_cyc && wbm_sel != 4'hf) sel_err <= sel_err + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (wbm_cyc && wbm_stb && wbm_ack) begin
      log_q.push_back({wbm_we, wbm_adr, wbm_we ? wbm_dat_o : wbm_dat_i});
      if (!wbm_we && wbm_adr == ADR_CMD_ISR) poll_reads <= poll_reads + 1;
      if (wbm_we && wbm_adr == ADR_ARGUMENT) arg_writes <= arg_writes + 1;
    end
    wbm_ack <= wbm_cyc && wbm_stb && !wbm_ack;
  end

  function automatic logic [40:0] ent(input logic we, input logic [7:0] a, input logic [31:0] d);
    return {we, a, d};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_q.delete();
    poll_reads = 0;
    arg_writes = 0;
    done_cnt   = 0;
  endtask

  task automatic send(input logic [13:0] c, input logic [31:0] a, input logic l);
    int k;
    k = 0;
    while (!req_ready && k < 200) begin
      cyc_n(1);
      k++;
    end
    chk("ready_before_send", 64'(req_ready), 64'd1);
    req_cmd   = c;
    req_arg   = a;
    req_long  = l;
    req_valid = 1'b1;
    cyc_n(1);
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      cyc_n(1);
    end
    chk("done_seen", 64'(ok), 64'd1);
    chk("ready_low_at_done", 64'(req_ready), 64'd0);
  endtask

  initial begin
    int n;
    bit found;
    rst_n = 1'b0; req_valid = 1'b0; req_cmd = '0; req_arg = '0; req_long = 1'b0;
    for (int i = 0; i < 4; i++) rr[i] = 32'h0;
    cyc_n(3);
    chk("rst_cyc", 64'(wbm_cyc), 64'd0);
    chk("rst_stb", 64'(wbm_stb), 64'd0);
    chk("rst_sel", 64'(wbm_sel), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready_in_reset", 64'(req_ready), 64'd0);
    rst_n = 1'b1;
    cyc_n(1);
    chk("rst_ready_after", 64'(req_ready), 64'd1);
    chk("rst_isr", 64'(isr), 64'd0);

    // Short command, CC appears on the fourth isr read
    clear_log(); raise_after = 3; raise_val = 5'h01; rr[0] = 32'h04050607;
    send(14'h0405, 32'h01020304, 1'b0);
    chk("s_busy", 64'(busy), 64'd1);
    wait_done();
    chk("s_isr", 64'(isr), 64'h01);
    chk("s_timeout", 64'(seq_timeout), 64'd0);
    chk("s_resp0", 64'(resp0), 64'h04050607);
    cyc_n(4);
    chk("s_ntrans", 64'(log_q.size()), 64'd9);
    if (log_q.size() == 9) begin
      chk("s_clr0", 64'(log_q[0]), 64'(ent(1'b1, 8'h34, 32'h0)));
      chk("s_wcmd", 64'(log_q[1]), 64'(ent(1'b1, 8'h04, 32'h0405)));
      chk("s_warg", 64'(log_q[2]), 64'(ent(1'b1, 8'h00, 32'h01020304)));
      chk("s_poll0", 64'(log_q[3]), 64'(ent(1'b0, 8'h34, 32'h0)));
      chk("s_poll3", 64'(log_q[6]), 64'(ent(1'b0, 8'h34, 32'h1)));
      chk("s_resp_rd", 64'(log_q[7]), 64'(ent(1'b0, 8'h08, 32'h04050607)));
      chk("s_clr1", 64'(log_q[8]), 64'(ent(1'b1, 8'h34, 32'h0)));
    end
    chk("s_arg_writes", 64'(arg_writes), 64'd1);
    chk("s_done_cnt", 64'(done_cnt), 64'd1);

    // Long response, four ascending reads
    clear_log(); raise_after = 0; raise_val = 5'h01;
    rr[0] = 32'h04050607; rr[1] = 32'h05060708; rr[2] = 32'h06070809; rr[3] = 32'h0708090a;
    send(14'h0802, 32'hdeadbeef, 1'b1);
    wait_done();
    chk("l_resp0", 64'(resp0), 64'h04050607);
    chk("l_resp1", 64'(resp1), 64'h05060708);
    chk("l_resp2", 64'(resp2), 64'h06070809);
    chk("l_resp3", 64'(resp3), 64'h0708090a);
    cyc_n(4);
    chk("l_ntrans", 64'(log_q.size()), 64'd9);
    if (log_q.size() == 9) begin
      chk("l_rd0", 64'(log_q[4]), 64'(ent(1'b0, 8'h08, 32'h04050607)));
      chk("l_rd1", 64'(log_q[5]), 64'(ent(1'b0, 8'h0c, 32'h05060708)));
      chk("l_rd2", 64'(log_q[6]), 64'(ent(1'b0, 8'h10, 32'h06070809)));
      chk("l_rd3", 64'(log_q[7]), 64'(ent(1'b0, 8'h14, 32'h0708090a)));
    end
    chk("l_done_cnt", 64'(done_cnt), 64'd1);

    // Error bits still lead to a response read
    clear_log(); raise_after = 0; raise_val = 5'h06; rr[0] = 32'h11223344;
    send(14'h0111, 32'h0, 1'b0);
    wait_done();
    chk("e_isr", 64'(isr), 64'h06);
    chk("e_timeout", 64'(seq_timeout), 64'd0);
    chk("e_resp0", 64'(resp0), 64'h11223344);
    cyc_n(4);
    chk("e_ntrans", 64'(log_q.size()), 64'd6);

    // Timeout after eight empty polls
    clear_log(); raise_after = 1000; raise_val = 5'h01;
    send(14'h0222, 32'h5, 1'b1);
    wait_done();
    chk("t_timeout", 64'(seq_timeout), 64'd1);
    chk("t_isr", 64'(isr), 64'h0);
    cyc_n(4);
    chk("t_polls", 64'(poll_reads), 64'd8);
    chk("t_ntrans", 64'(log_q.size()), 64'd12);
    if (log_q.size() == 12) chk("t_clr1", 64'(log_q[11]), 64'(ent(1'b1, 8'h34, 32'h0)));
    n = 0;
    foreach (log_q[i]) if (log_q[i][39:32] != 8'h34 && log_q[i][39:32] != 8'h04 && log_q[i][39:32] != 8'h00) n++;
    chk("t_no_resp_reads", 64'(n), 64'd0);

    // Back-to-back with req_valid held high
    clear_log(); raise_after = 0; raise_val = 5'h01; rr[0] = 32'h0;
    req_cmd = 14'h0333; req_arg = 32'h77; req_long = 1'b0; req_valid = 1'b1;
    cyc_n(1);
    chk("b_timeout_cleared", 64'(seq_timeout), 64'd0);
    wait_done();
    cyc_n(1);
    chk("b_idle_after_done", 64'(busy), 64'd0);
    chk("b_ready_after_done", 64'(req_ready), 64'd1);
    cyc_n(1);
    chk("b_second_accept", 64'(busy), 64'd1);
    req_valid = 1'b0;
    wait_done();
    cyc_n(4);
    chk("b_ntrans", 64'(log_q.size()), 64'd12);
    if (log_q.size() == 12) chk("b_second_clr0", 64'(log_q[6]), 64'(ent(1'b1, 8'h34, 32'h0)));
    chk("b_done_cnt", 64'(done_cnt), 64'd2);

    // Requests while busy are dropped
    clear_log();
    send(14'h0444, 32'h88, 1'b0);
    cyc_n(3);
    req_cmd = 14'h3fff; req_valid = 1'b1; cyc_n(1); req_valid = 1'b0;
    cyc_n(4);
    req_valid = 1'b1; cyc_n(1); req_valid = 1'b0;
    wait_done();
    cyc_n(12);
    chk("i_ntrans", 64'(log_q.size()), 64'd6);
    if (log_q.size() == 6) chk("i_cmd", 64'(log_q[1]), 64'(ent(1'b1, 8'h04, 32'h0444)));
    chk("i_done_cnt", 64'(done_cnt), 64'd1);
    chk("i_idle", 64'(busy), 64'd0);

    // Asynchronous reset during a poll
    clear_log(); raise_after = 1000; rr[0] = 32'hcafef00d;
    send(14'h0555, 32'h99, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (wbm_stb && !wbm_we && wbm_adr == ADR_CMD_ISR) begin
        found = 1'b1;
        break;
      end
      cyc_n(1);
    end
    chk("r_poll_seen", 64'(found), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("r_cyc", 64'(wbm_cyc), 64'd0);
    chk("r_stb", 64'(wbm_stb), 64'd0);
    chk("r_adr", 64'(wbm_adr), 64'd0);
    chk("r_busy", 64'(busy), 64'd0);
    chk("r_ready", 64'(req_ready), 64'd0);
    chk("r_resp0", 64'(resp0), 64'd0);
    cyc_n(2);
    rst_n = 1'b1;
    cyc_n(1);
    chk("r_ready_after", 64'(req_ready), 64'd1);
    clear_log(); raise_after = 0; raise_val = 5'h01;
    send(14'h0666, 32'haa, 1'b0);
    wait_done();
    chk("r_isr", 64'(isr), 64'h01);
    chk("r_resp0_new", 64'(resp0), 64'hcafef00d);
    cyc_n(4);
    chk("r_ntrans", 64'(log_q.size()), 64'd6);
    chk("sel_always_f", 64'(sel_err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
